// File: rtl/ctrl_unit_if.sv
// ctrl_unit_if -- control/status bundle between the polynomial sequencer
// (ctrl_unit) and its operative block.
//   start       request to evaluate Y = (A*X + B)*X + C
//   overflow    alu overflow flag from the operative block
//   zero        Reg_H == 0 flag from the operative block
//   LX/LS/LH    load enables for Reg_X, Reg_S, Reg_H
//   H           alu operation select
//   M0/M1/M2    mux selects
//   busy/done   sequencer status, done is a one-cycle completion pulse
//   error       sticky overflow of the last evaluation
//   res_zero    zero flag captured at completion
// master: requester/operative-block side; slave: the sequencer.
interface ctrl_unit_if;
    logic       start;
    logic       overflow;
    logic       zero;
    logic       LX, LS, LH;
    logic       H;
    logic [1:0] M0, M1, M2;
    logic       busy;
    logic       done;
    logic       error;
    logic       res_zero;

    modport master (
        output start, overflow, zero,
        input  LX, LS, LH, H, M0, M1, M2, busy, done, error, res_zero
    );

    modport slave (
        input  start, overflow, zero,
        output LX, LS, LH, H, M0, M1, M2, busy, done, error, res_zero
    );
endinterface

// File: rtl/ctrl_unit.sv
// ctrl_unit -- Moore sequencer for Y = (A*X + B)*X + C.
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-low reset
//   bus   ctrl_unit_if.slave (start/overflow/zero in, control + status out)
// Parameter:
//   H_MUL value of H selecting multiply; ~H_MUL selects add.
// Build option:
//   CTRL_OVF_ABORT_EN  overflow in MUL_AX/ADD_B/MUL_X jumps straight to DONE
//                      (Reg_H is not loaded); overflow in ADD_C still
//                      completes normally. Undefined: always run to the end.
// Sequence: IDLE -> LOAD_X -> MUL_AX -> ADD_B -> MUL_X -> ADD_C -> DONE -> IDLE
module ctrl_unit #(
    parameter logic H_MUL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_X = 3'd1,
        MUL_AX = 3'd2,
        ADD_B  = 3'd3,
        MUL_X  = 3'd4,
        ADD_C  = 3'd5,
        DONE   = 3'd6
    } state_t;

    typedef struct packed {
        logic       lx;
        logic       ls;
        logic       lh;
        logic       h;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       busy;
        logic       done;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   error_q, error_d;
    logic   res_zero_q, res_zero_d;

    // Control word for a state. Outputs are registered from the next state,
    // so ctrl_q always matches decode(state_q): pure Moore, no glitches.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c      = '0;
        c.h    = ~H_MUL;
        c.busy = (s != IDLE);
        case (s)
            LOAD_X: c.lx = 1'b1;
            MUL_AX: begin                       // Reg_S = A * Reg_X
                c.m0 = 2'b01; c.m1 = 2'b00; c.m2 = 2'b00;
                c.h  = H_MUL; c.ls = 1'b1;
            end
            ADD_B: begin                        // Reg_S = B + Reg_S
                c.m0 = 2'b10; c.m1 = 2'b00; c.m2 = 2'b10;
                c.ls = 1'b1;
            end
            MUL_X: begin                        // Reg_S = Reg_X * Reg_S
                c.m1 = 2'b01; c.m2 = 2'b10;
                c.h  = H_MUL; c.ls = 1'b1;
            end
            ADD_C: begin                        // Reg_H = C + Reg_S
                c.m0 = 2'b11; c.m1 = 2'b00; c.m2 = 2'b10;
                c.lh = 1'b1;
            end
            DONE:    c.done = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    logic in_alu_state;
    assign in_alu_state = (state_q == MUL_AX) || (state_q == ADD_B) ||
                          (state_q == MUL_X)  || (state_q == ADD_C);

    always_comb begin
        state_d    = state_q;
        error_d    = error_q;
        res_zero_d = res_zero_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = LOAD_X;
                error_d = 1'b0;
            end
            LOAD_X: state_d = MUL_AX;
            MUL_AX: state_d = ADD_B;
            ADD_B:  state_d = MUL_X;
            MUL_X:  state_d = ADD_C;
            ADD_C:  state_d = DONE;
            DONE: begin
                state_d    = IDLE;
                res_zero_d = bus.zero;
            end
            default: state_d = IDLE;
        endcase
        if (in_alu_state && bus.overflow) begin
            error_d = 1'b1;
`ifdef CTRL_OVF_ABORT_EN
            // Skip the remaining steps; ADD_C already heads to DONE.
            if (state_q != ADD_C) state_d = DONE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ctrl_q     <= decode(IDLE);
            error_q    <= 1'b0;
            res_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= decode(state_d);
            error_q    <= error_d;
            res_zero_q <= res_zero_d;
        end
    end

    assign bus.LX       = ctrl_q.lx;
    assign bus.LS       = ctrl_q.ls;
    assign bus.LH       = ctrl_q.lh;
    assign bus.H        = ctrl_q.h;
    assign bus.M0       = ctrl_q.m0;
    assign bus.M1       = ctrl_q.m1;
    assign bus.M2       = ctrl_q.m2;
    assign bus.busy     = ctrl_q.busy;
    assign bus.done     = ctrl_q.done;
    assign bus.error    = error_q;
    assign bus.res_zero = res_zero_q;

endmodule
